stream_mux_rr: RTL and testbench

//   Parametrised N-to-1 packet multiplexer with registered output. Successor to the 5-to-1 operand mux.

---
 rtl/stream_mux_rr.sv | 139 +++++++++++++
 tb/tb_stream_mux_rr.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/stream_mux_rr.sv
// N-to-1 valid/ready packet multiplexer with a registered output stage.
// A round-robin or fixed-select grant is held from the first beat of a packet to its last beat.
//
// state | meaning
// IDLE  | no packet open; the grant is chosen combinationally each cycle
// LOCK  | a multi-beat packet is open; the grant stays on grant_q until its last beat
module stream_mux_rr #(
  parameter int N     = 5,
  parameter int W     = 16,
  parameter int SEL_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             mode,
  input  logic [SEL_W-1:0] sel,
  input  logic [N-1:0]     in_valid,
  output logic [N-1:0]     in_ready,
  input  logic [N-1:0]     in_last,
  input  logic [N*W-1:0]   in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_data,
  output logic             out_last,
  output logic [SEL_W-1:0] out_chan
);

  typedef enum logic {IDLE, LOCK} state_t;

  state_t           state_q, state_d;
  logic [SEL_W-1:0] grant_q, grant_d;
  logic [SEL_W-1:0] rr_ptr_q, rr_ptr_d;
  logic             out_valid_q, out_valid_d;
  logic [W-1:0]     out_data_q, out_data_d;
  logic             out_last_q, out_last_d;
  logic [SEL_W-1:0] out_chan_q, out_chan_d;

  logic [SEL_W-1:0] cur_grant;
  logic             grant_ok;
  logic             adv;
  logic             hs;
  logic             sel_valid;
  logic             sel_last;
  logic [W-1:0]     sel_data;
  int               idx;

  assign adv = !out_valid_q || out_ready;

  // Scan from the highest offset down so the channel nearest rr_ptr wins.
  always_comb begin
    cur_grant = '0;
    grant_ok  = 1'b0;
    idx       = 0;
    if (state_q == LOCK) begin
      cur_grant = grant_q;
      grant_ok  = 1'b1;
    end else if (mode) begin
      cur_grant = sel;
      for (int i = 0; i < N; i++)
        if (sel == SEL_W'(i)) grant_ok = in_valid[i];
    end else begin
      for (int k = N - 1; k >= 0; k--) begin
        idx = int'(rr_ptr_q) + k;
        if (idx >= N) idx = idx - N;
        if (in_valid[idx]) begin
          cur_grant = SEL_W'(idx);
          grant_ok  = 1'b1;
        end
      end
    end
  end

  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = '0;
    in_ready  = '0;
    for (int i = 0; i < N; i++) begin
      if (cur_grant == SEL_W'(i)) begin
        sel_valid   = in_valid[i];
        sel_last    = in_last[i];
        sel_data    = in_data[i*W +: W];
        in_ready[i] = rst_n && adv && grant_ok;
      end
    end
  end

  assign hs = adv && grant_ok && sel_valid;

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    rr_ptr_d    = rr_ptr_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    out_chan_d  = out_chan_q;
    if (hs) begin
      out_valid_d = 1'b1;
      out_data_d  = sel_data;
      out_last_d  = sel_last;
      out_chan_d  = cur_grant;
      grant_d     = cur_grant;
      if (sel_last) begin
        state_d  = IDLE;
        rr_ptr_d = (cur_grant == SEL_W'(N - 1)) ? '0 : cur_grant + SEL_W'(1);
      end else begin
        state_d = LOCK;
      end
    end else if (adv) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      rr_ptr_q    <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      out_chan_q  <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      rr_ptr_q    <= rr_ptr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      out_chan_q  <= out_chan_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign out_chan  = out_chan_q;

endmodule

// File: tb/tb_stream_mux_rr.sv
// Directed and randomized bench for stream_mux_rr against a transaction-level model
// and an in-order beat scoreboard.
module tb_stream_mux_rr;
  localparam int N = 5;
  localparam int W = 16;
  localparam int SEL_W = 3;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             mode;
  logic [SEL_W-1:0] sel;
  logic [N-1:0]     in_valid;
  logic [N-1:0]     in_ready;
  logic [N-1:0]     in_last;
  logic [N*W-1:0]   in_data;
  logic             out_valid;
  logic             out_ready;
  logic [W-1:0]     out_data;
  logic             out_last;
  logic [SEL_W-1:0] out_chan;

  stream_mux_rr #(.N(N), .W(W), .SEL_W(SEL_W)) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .sel(sel),
    .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .out_chan(out_chan)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // model: output register contents, open packet owner (-1 = none), fairness pointer
  logic        m_ov;
  logic [15:0] m_data;
  logic        m_last;
  int          m_chan;
  int          m_lock;
  int          m_ptr;
  logic [31:0] sb[$];

  logic [15:0] cd [N] = '{16'h0000, 16'h0001, 16'h0010, 16'h0011, 16'h0101};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_ov = 1'b0; m_data = '0; m_last = 1'b0; m_chan = 0; m_lock = -1; m_ptr = 0;
    sb.delete();
  endtask

  task automatic cyc(output int hs_ch);
    int ch;
    logic adv;
    logic [N-1:0] exp_rdy;
    logic [31:0] got;
    @(negedge clk);
    if (out_valid && out_ready) begin
      got = {12'b0, out_chan, out_last, out_data};
      if (sb.size() == 0) check("sb_extra_beat", got, 32'hFFFF_FFFF);
      else check("sb_order", got, sb.pop_front());
    end
    adv = !m_ov || out_ready;
    ch = -1;
    if (m_lock >= 0) ch = m_lock;
    else if (mode) begin
      if (sel < N && in_valid[sel]) ch = int'(sel);
    end else begin
      for (int k = 0; k < N; k++)
        if (ch < 0 && in_valid[(m_ptr + k) % N]) ch = (m_ptr + k) % N;
    end
    exp_rdy = (adv && ch >= 0) ? N'(1 << ch) : '0;
    check("in_ready", 32'(in_ready), 32'(exp_rdy));
    check("out_valid", 32'(out_valid), 32'(m_ov));
    check("out_data", 32'(out_data), 32'(m_data));
    check("out_last", 32'(out_last), 32'(m_last));
    check("out_chan", 32'(out_chan), 32'(m_chan));
    hs_ch = (adv && ch >= 0 && in_valid[ch]) ? ch : -1;
    if (hs_ch >= 0) begin
      m_ov = 1'b1;
      m_data = in_data[hs_ch*W +: W];
      m_last = in_last[hs_ch];
      m_chan = hs_ch;
      sb.push_back({12'b0, 3'(hs_ch), m_last, m_data});
      if (m_last) begin
        m_lock = -1;
        m_ptr = (hs_ch + 1) % N;
      end else m_lock = hs_ch;
    end else if (adv) m_ov = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic set_all(input logic [N-1:0] v, input logic [N-1:0] l);
    in_valid = v;
    in_last  = l;
    for (int i = 0; i < N; i++) in_data[i*W +: W] = cd[i];
  endtask

  task automatic new_beat(input int i);
    in_valid[i] = 1'b1;
    in_data[i*W +: W] = 16'($urandom);
    in_last[i] = ($urandom_range(0, 2) == 0);
  endtask

  int h;
  logic [15:0] sd;
  logic [2:0]  sc;
  logic        sl;
  int          exp_seq [6] = '{0, 1, 2, 3, 4, 0};

  initial begin
    rst_n = 1'b0; mode = 1'b0; sel = '0; out_ready = 1'b1;
    in_valid = '0; in_last = '0; in_data = '0;
    model_reset();
    #12;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_chan", 32'(out_chan), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;

    // round-robin over all five channels
    set_all('1, '1);
    for (int j = 0; j < 6; j++) begin
      cyc(h);
      check("rr_chan", 32'(out_chan), 32'(exp_seq[j]));
      check("rr_data", 32'(out_data), 32'(cd[exp_seq[j]]));
    end

    // fixed select, then an out-of-range select
    mode = 1'b1; sel = 3'd4;
    cyc(h);
    check("fix_data", 32'(out_data), 32'h0101);
    check("fix_chan", 32'(out_chan), 32'd4);
    sel = 3'd5;
    cyc(h);
    check("sel5_out_valid", 32'(out_valid), 32'd0);
    check("sel5_in_ready", 32'(in_ready), 32'd0);

    // single beat from ch1 puts the pointer on ch2
    sel = 3'd1;
    cyc(h);
    check("ptr_setup_chan", 32'(out_chan), 32'd1);

    // ch2 three-beat packet while ch0, ch1, ch3 stay valid
    mode = 1'b0;
    set_all(5'b01111, 5'b00011);
    cyc(h); check("lock_b1", 32'(out_chan), 32'd2);
    cyc(h); check("lock_b2", 32'(out_chan), 32'd2);
    in_last[2] = 1'b1;
    cyc(h); check("lock_b3", 32'(out_chan), 32'd2);
    check("lock_b3_last", 32'(out_last), 32'd1);
    cyc(h); check("next_ch3", 32'(out_chan), 32'd3);

    // mode switch to sel=0 during the ch3 packet
    mode = 1'b1; sel = 3'd0;
    cyc(h); check("msw_b2", 32'(out_chan), 32'd3);
    in_last[3] = 1'b1;
    cyc(h); check("msw_b3", 32'(out_chan), 32'd3);
    cyc(h); check("msw_ch0", 32'(out_chan), 32'd0);

    // backpressure mid-stream
    mode = 1'b0;
    set_all('1, '1);
    for (int j = 0; j < 3; j++) cyc(h);
    out_ready = 1'b0;
    sd = out_data; sc = out_chan; sl = out_last;
    for (int j = 0; j < 4; j++) begin
      cyc(h);
      check("bp_data", 32'(out_data), 32'(sd));
      check("bp_chan", 32'(out_chan), 32'(sc));
      check("bp_last", 32'(out_last), 32'(sl));
      check("bp_in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    for (int j = 0; j < 4; j++) cyc(h);

    // asynchronous reset mid-run, no clock edge
    #2 rst_n = 1'b0;
    #1;
    check("arst_out_valid", 32'(out_valid), 32'd0);
    check("arst_out_data", 32'(out_data), 32'd0);
    check("arst_in_ready", 32'(in_ready), 32'd0);
    model_reset();
    @(posedge clk); #1 rst_n = 1'b1;

    // randomized traffic
    in_valid = '0;
    for (int c = 0; c < 400; c++) begin
      cyc(h);
      for (int i = 0; i < N; i++) begin
        if (h == i) begin
          if ($urandom_range(0, 3) != 0) new_beat(i);
          else in_valid[i] = 1'b0;
        end else if (!in_valid[i] && $urandom_range(0, 1) == 1) new_beat(i);
      end
      out_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 15) == 0) mode = ~mode;
      sel = 3'($urandom_range(0, 7));
    end

    // drain
    in_valid = '0; out_ready = 1'b1;
    for (int j = 0; j < 3; j++) cyc(h);
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
